// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the fetch/data memory port arbiter.
package mem_port_arbiter_pkg;

    // Parameter defaults
    localparam int unsigned AW_DEFAULT      = 32;
    localparam int unsigned DW_DEFAULT      = 32;
    localparam int unsigned TIMEOUT_DEFAULT = 16;

    // Watchdog counter width; covers TIMEOUT values up to 255
    localparam int unsigned WD_CNT_W = 8;

    // FSM state encoding
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] BUSY_I = 2'd1;
    localparam logic [1:0] BUSY_D = 2'd2;

endpackage

// File: rtl/arb_watchdog.sv
// BUSY-cycle watchdog: cleared on grant, counts cycles spent waiting on memory.
module arb_watchdog
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                enable,
    output logic [WD_CNT_W-1:0] count,
    output logic                expired
);

    logic [WD_CNT_W-1:0] count_q;
    logic [WD_CNT_W-1:0] count_d;

    // Next count: clear has priority over increment
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + WD_CNT_W'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count   = count_q;
    assign expired = (count_q == WD_CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and
// load/store, with a per-transaction timeout that completes the ack with err.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned AW      = AW_DEFAULT,
    parameter int unsigned DW      = DW_DEFAULT,
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    // Instruction fetch requester
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_ack,
    // Load/store requester
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    // Shared completion data
    output logic [DW-1:0] rdata,
    output logic          err,
    // Memory port
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready
);

    logic [1:0]    state_q,     state_d;
    logic          last_d_q,    last_d_d;     // 1 = data served last, 0 = fetch
    logic          mem_en_q,    mem_en_d;
    logic          mem_we_q,    mem_we_d;
    logic [AW-1:0] mem_addr_q,  mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;

    logic          i_ack_c;
    logic          d_ack_c;
    logic          err_c;
    logic [DW-1:0] rdata_c;

    logic                wd_clear;
    logic                wd_enable;
    logic [WD_CNT_W-1:0] wd_count;
    logic                wd_expired;

    logic grant_d;
    logic grant_i;
    logic busy_done;

    // Round-robin choice: when both are pending, serve the one not served last
    assign grant_d = d_req && (!i_req || !last_d_q);
    assign grant_i = i_req && (!d_req ||  last_d_q);

    // Next-state, registered-output next values and completion outputs
    always_comb begin
        state_d     = state_q;
        last_d_d    = last_d_q;
        mem_en_d    = mem_en_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        wd_clear    = 1'b0;
        wd_enable   = 1'b0;
        i_ack_c     = 1'b0;
        d_ack_c     = 1'b0;
        err_c       = 1'b0;
        rdata_c     = '0;
        busy_done   = 1'b0;

        case (state_q)
            IDLE: begin
                if (grant_d) begin
                    state_d     = BUSY_D;
                    last_d_d    = 1'b1;
                    mem_en_d    = 1'b1;
                    mem_we_d    = d_we;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                    wd_clear    = 1'b1;
                end else if (grant_i) begin
                    state_d     = BUSY_I;
                    last_d_d    = 1'b0;
                    mem_en_d    = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = i_addr;
                    mem_wdata_d = '0;
                    wd_clear    = 1'b1;
                end
            end

            BUSY_I, BUSY_D: begin
                // A memory response wins over a timeout landing in the same cycle
                if (mem_ready) begin
                    busy_done = 1'b1;
                    rdata_c   = mem_rdata;
                end else if (wd_expired) begin
                    busy_done = 1'b1;
                    err_c     = 1'b1;
                end else begin
                    wd_enable = (wd_count != WD_CNT_W'(TIMEOUT - 1));
                end

                if (busy_done) begin
                    i_ack_c  = (state_q == BUSY_I);
                    d_ack_c  = (state_q == BUSY_D);
                    state_d  = IDLE;
                    mem_en_d = 1'b0;
                    mem_we_d = 1'b0;
                end
            end

            default: begin
                state_d  = IDLE;
                mem_en_d = 1'b0;
                mem_we_d = 1'b0;
            end
        endcase
    end

    // State and memory-port registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            last_d_q    <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            last_d_q    <= last_d_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .count   (wd_count),
        .expired (wd_expired)
    );

    assign i_ack     = i_ack_c;
    assign d_ack     = d_ack_c;
    assign err       = err_c;
    assign rdata     = rdata_c;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (default parameters).
module tb_mem_port_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic          clk;
    logic          rst;
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_ack;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_ack;
    logic [DW-1:0] rdata;
    logic          err;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;

    int checks;
    int fails;

    mem_port_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_ack     (i_ack),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_ack     (d_ack),
        .rdata     (rdata),
        .err       (err),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Move to the falling edge for sampling
    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".mem_en"}, 64'(mem_en), 64'd0);
        check({tag, ".i_ack"},  64'(i_ack),  64'd0);
        check({tag, ".d_ack"},  64'(d_ack),  64'd0);
        check({tag, ".err"},    64'(err),    64'd0);
        check({tag, ".rdata"},  64'(rdata),  64'd0);
    endtask

    // Global time bound
    initial begin
        #1000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "time bound exceeded");
    end

    initial begin
        logic exp_d;

        checks    = 0;
        fails     = 0;
        rst       = 1'b1;
        i_req     = 1'b0;
        i_addr    = '0;
        d_req     = 1'b0;
        d_we      = 1'b0;
        d_addr    = '0;
        d_wdata   = '0;
        mem_rdata = '0;
        mem_ready = 1'b0;

        // Reset state
        step();
        step();
        at_neg();
        check_idle("reset");
        check("reset.mem_we",    64'(mem_we),    64'd0);
        check("reset.mem_addr",  64'(mem_addr),  64'd0);
        check("reset.mem_wdata", 64'(mem_wdata), 64'd0);
        step();
        rst = 1'b0;

        // Single fetch with one-cycle memory latency
        i_req  = 1'b1;
        i_addr = 32'h100;
        at_neg();
        check("fetch.pre_grant_en", 64'(mem_en), 64'd0);
        step();
        mem_ready = 1'b1;
        mem_rdata = 32'h1234_5678;
        at_neg();
        check("fetch.mem_en",   64'(mem_en),   64'd1);
        check("fetch.mem_we",   64'(mem_we),   64'd0);
        check("fetch.mem_addr", 64'(mem_addr), 64'h100);
        check("fetch.i_ack",    64'(i_ack),    64'd1);
        check("fetch.d_ack",    64'(d_ack),    64'd0);
        check("fetch.rdata",    64'(rdata),    64'h1234_5678);
        check("fetch.err",      64'(err),      64'd0);
        step();
        i_req     = 1'b0;
        mem_ready = 1'b0;
        at_neg();
        check_idle("fetch.after");

        // Fresh reset, then simultaneous requests held: d, i, d, i
        rst = 1'b1;
        step();
        rst     = 1'b0;
        i_req   = 1'b1;
        i_addr  = 32'h200;
        d_req   = 1'b1;
        d_we    = 1'b0;
        d_addr  = 32'h300;
        for (int k = 0; k < 4; k++) begin
            exp_d = ((k % 2) == 0);
            step();
            mem_ready = 1'b1;
            mem_rdata = 32'hA000_0000 + 32'(k);
            at_neg();
            check("rr.d_ack",    64'(d_ack),    64'(exp_d));
            check("rr.i_ack",    64'(i_ack),    64'(!exp_d));
            check("rr.mem_addr", 64'(mem_addr), exp_d ? 64'h300 : 64'h200);
            check("rr.rdata",    64'(rdata),    64'h0A000_0000 + 64'(k));
            step();
            mem_ready = 1'b0;
            at_neg();
            check("rr.idle_acks", 64'({i_ack, d_ack}), 64'd0);
        end
        i_req = 1'b0;
        d_req = 1'b0;

        // Store with three-cycle memory latency; inputs changed mid-transaction
        step();
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 32'h40;
        d_wdata = 32'hDEAD_BEEF;
        step();
        d_addr  = 32'h44;
        d_wdata = 32'h0;
        d_we    = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (k == 2) mem_ready = 1'b1;
            at_neg();
            check("store.mem_en",    64'(mem_en),    64'd1);
            check("store.mem_we",    64'(mem_we),    64'd1);
            check("store.mem_addr",  64'(mem_addr),  64'h40);
            check("store.mem_wdata", 64'(mem_wdata), 64'hDEAD_BEEF);
            check("store.d_ack",     64'(d_ack),     64'(k == 2));
            check("store.err",       64'(err),       64'd0);
            step();
        end
        mem_ready = 1'b0;
        d_req     = 1'b0;
        at_neg();
        check_idle("store.after");

        // Fetch timeout; request dropped early must still be acked
        step();
        i_req     = 1'b1;
        i_addr    = 32'h500;
        mem_rdata = 32'hAAAA_5555;
        step();
        for (int n = 0; n < 16; n++) begin
            at_neg();
            check("tmo.i_ack",  64'(i_ack),  64'(n == 15));
            check("tmo.err",    64'(err),    64'(n == 15));
            check("tmo.mem_en", 64'(mem_en), 64'd1);
            if (n == 15) check("tmo.rdata", 64'(rdata), 64'd0);
            step();
            if (n == 3) i_req = 1'b0;
        end
        at_neg();
        check_idle("tmo.after");

        // mem_ready coinciding with the timeout cycle completes normally
        step();
        d_req     = 1'b1;
        d_we      = 1'b0;
        d_addr    = 32'h600;
        mem_rdata = 32'hC0DE_0001;
        step();
        for (int n = 0; n < 16; n++) begin
            mem_ready = (n == 15);
            at_neg();
            check("race.d_ack", 64'(d_ack), 64'(n == 15));
            check("race.err",   64'(err),   64'd0);
            if (n == 15) check("race.rdata", 64'(rdata), 64'hC0DE_0001);
            step();
        end
        mem_ready = 1'b0;
        d_req     = 1'b0;
        at_neg();
        check_idle("race.after");

        // mem_ready while idle is ignored
        step();
        mem_ready = 1'b1;
        mem_rdata = 32'hFFFF_FFFF;
        for (int n = 0; n < 3; n++) begin
            at_neg();
            check_idle("idle_ready");
            step();
        end
        mem_ready = 1'b0;

        // Reset during BUSY_D aborts without ack; held request re-granted
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 32'h80;
        step();
        at_neg();
        check("rst_mid.busy_en", 64'(mem_en), 64'd1);
        #1;
        rst = 1'b1;
        #1;
        check("rst_mid.async_en",   64'(mem_en),   64'd0);
        check("rst_mid.d_ack",      64'(d_ack),    64'd0);
        check("rst_mid.mem_addr",   64'(mem_addr), 64'd0);
        step();
        at_neg();
        check_idle("rst_mid.held");
        step();
        rst = 1'b0;
        at_neg();
        check("rst_mid.no_early_grant", 64'(mem_en), 64'd0);
        step();
        mem_ready = 1'b1;
        mem_rdata = 32'h0BAD_F00D;
        at_neg();
        check("rst_mid.regrant_addr", 64'(mem_addr), 64'h80);
        check("rst_mid.d_ack2",       64'(d_ack),    64'd1);
        check("rst_mid.rdata",        64'(rdata),    64'h0BAD_F00D);
        check("rst_mid.err",          64'(err),      64'd0);
        step();
        mem_ready = 1'b0;
        d_req     = 1'b0;
        at_neg();
        check_idle("rst_mid.after");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter AW, default 32, address width.
REQ-002 SHALL have parameter DW, default 32, data width.
REQ-003 SHALL have parameter TIMEOUT, default 16, the number of BUSY cycles without mem_ready before aborting (range 2..255).
REQ-004 clk  input  1  sole clock; all state updates on posedge clk.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 i_req  input  1  instruction-fetch request, held until i_ack.
REQ-007 i_addr  input  AW  fetch address.
REQ-008 i_ack  output  1  one-cycle fetch completion pulse.
REQ-009 d_req  input  1  load/store request, held until d_ack.
REQ-010 d_we  input  1  1 = store, 0 = load.
REQ-011 d_addr  input  AW  data address.
REQ-012 d_wdata  input  DW  store data.
REQ-013 d_ack  output  1  one-cycle data completion pulse.
REQ-014 rdata  output  DW  read data, valid only while i_ack or d_ack is high.
REQ-015 err  output  1  high with the ack when the transaction timed out.
REQ-016 mem_en  output  1  memory access strobe.
REQ-017 mem_we  output  1  memory write enable.
REQ-018 mem_addr  output  AW  memory address.
REQ-019 mem_wdata  output  DW  memory write data.
REQ-020 mem_rdata  input  DW  memory read data.
REQ-021 mem_ready  input  1  memory completion, any latency >= 1 cycle.

Function
REQ-022 The FSM SHALL have the states IDLE, BUSY_I and BUSY_D.
REQ-023 IDLE, d_req only SHALL transition to BUSY_D; i_req only to BUSY_I; both pending to the requester not served last (round-robin); neither to stay in IDLE.
REQ-024 The last-served flag SHALL reset to "fetch", so a simultaneous first request grants data.
REQ-025 On grant, mem_addr, mem_we and mem_wdata SHALL be registered from the granted requester; mem_we SHALL be 0 for fetch.
REQ-026 mem_en SHALL be high for every cycle in BUSY_I or BUSY_D, and 0 in IDLE.
REQ-027 In BUSY_x with mem_ready=1, the block SHALL assert x_ack for that cycle, drive rdata=mem_rdata and err=0, and go to IDLE next.
REQ-028 The minimum request-to-ack latency SHALL be 2 cycles: grant edge, then mem_ready in the first BUSY cycle.
REQ-029 A watchdog counter SHALL clear on entering BUSY and increment each BUSY cycle without mem_ready.
REQ-030 When the watchdog reaches TIMEOUT-1 without mem_ready, the block SHALL pulse x_ack with err=1 and rdata=0, and return to IDLE.
REQ-031 mem_ready and the timeout in the same cycle SHALL resolve as a normal completion (err=0).
REQ-032 Requests SHALL be sampled only in IDLE; address/data changes during BUSY SHALL be ignored.
REQ-033 A request dropped before its ack SHALL NOT abort the transaction, and the ack is still issued.
REQ-034 i_ack and d_ack SHALL never be high in the same cycle; at most one transaction SHALL be outstanding.
REQ-035 mem_ready in IDLE SHALL be ignored.

Reset
REQ-036 While rst=1, the block SHALL hold state=IDLE, last-served=fetch, watchdog=0, all mem_* outputs 0, i_ack=d_ack=err=0 and rdata=0.
REQ-037 rst asserted mid-transaction SHALL abort it immediately with no ack; the requester re-arbitrates after release.
REQ-038 The first grant SHALL occur no earlier than the first posedge after rst deasserts.

Structure
REQ-039 A shared package SHALL hold the FSM state encoding (IDLE=2'd0, BUSY_I=2'd1, BUSY_D=2'd2) and the parameter defaults.
REQ-040 The watchdog SHALL be one sub-module, arb_watchdog (clear, enable, count, expired); all other logic stays in a single module.

Verification
REQ-041 i_req=1, addr 0x100; mem_ready 1 cycle after mem_en -> i_ack 2 cycles after request, rdata=mem_rdata, mem_we=0.
REQ-042 i_req and d_req raised in the same cycle after reset, both held -> d_ack first, then i_ack; repeated -> strict alternation.
REQ-043 Store d_we=1, addr 0x40, wdata 0xDEADBEEF, mem_ready after 3 cycles -> mem_we=1, mem_wdata held stable for all 3 BUSY cycles, single d_ack.
REQ-044 mem_ready never asserted, TIMEOUT=16 -> after 16 BUSY cycles, ack with err=1 and rdata=0, then IDLE.
REQ-045 rst pulsed during BUSY_D -> mem_en low asynchronously, no d_ack, d_req still high after release -> fresh grant and normal completion.
REQ-046 mem_ready=1 in IDLE with no requests -> no ack and no state change.
